// File: rtl/nf10_cutter_pkg.sv
// Shared definitions for the NF10 packet-cutter AXI4-Lite register block:
// register offsets, AXI response codes, handshake FSM states and a byte-strobe merge helper.
package nf10_cutter_pkg;

    localparam logic [7:0] CUT_EN_OFF  = 8'h00;
    localparam logic [7:0] WORD_OFF    = 8'h04;
    localparam logic [7:0] OFFSET_OFF  = 8'h08;
    localparam logic [7:0] BYTES_OFF   = 8'h0C;
    localparam logic [7:0] PKT_CNT_OFF = 8'h10;
    localparam logic [7:0] VERSION_OFF = 8'h14;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_HAVE_AW = 2'd1,
        W_HAVE_W  = 2'd2,
        W_RESP    = 2'd3
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rd_state_e;

    // Byte lanes with their strobe set take the new value, the rest keep the old one.
    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[i*8 +: 8] = new_val[i*8 +: 8];
            end else begin
                res[i*8 +: 8] = old_val[i*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/nf10_cutter_axi_lite_ctrl.sv
// AXI4-Lite handshake engine: AW/W/B and AR/R FSMs presenting a simple
// single-cycle wr_en / rd_en strobe interface to the register file.
module nf10_cutter_axi_lite_ctrl
    import nf10_cutter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wvalid,
    output logic                wready,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic                arvalid,
    output logic                arready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rvalid,
    input  logic                rready,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]   wr_data,
    output logic [DATA_W/8-1:0] wr_strb,
    input  logic                wr_err,
    output logic                rd_en,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic [DATA_W-1:0]   rd_data,
    input  logic                rd_err
);

    wr_state_e             w_state_r, w_state_s;
    rd_state_e             r_state_r, r_state_s;
    logic                  awready_r, awready_s, wready_r, wready_s, bvalid_r, bvalid_s;
    logic                  arready_r, arready_s, rvalid_r, rvalid_s;
    logic [1:0]            bresp_r, rresp_r;
    logic [DATA_W-1:0]     rdata_r;
    logic [ADDR_W-1:0]     aw_addr_r;
    logic [DATA_W-1:0]     w_data_r;
    logic [DATA_W/8-1:0]   w_strb_r;
    logic                  aw_fire_s, w_fire_s, ar_fire_s;

    assign aw_fire_s = awvalid & awready_r;
    assign w_fire_s  = wvalid & wready_r;
    assign ar_fire_s = arvalid & arready_r;

    // Whichever half arrived earlier comes from its latch, the other from the live bus.
    assign wr_addr = (w_state_r == W_HAVE_AW) ? aw_addr_r : awaddr;
    assign wr_data = (w_state_r == W_HAVE_W)  ? w_data_r  : wdata;
    assign wr_strb = (w_state_r == W_HAVE_W)  ? w_strb_r  : wstrb;
    assign rd_en   = ar_fire_s;
    assign rd_addr = araddr;

    assign awready = awready_r;
    assign wready  = wready_r;
    assign bvalid  = bvalid_r;
    assign bresp   = bresp_r;
    assign arready = arready_r;
    assign rvalid  = rvalid_r;
    assign rdata   = rdata_r;
    assign rresp   = rresp_r;

    // Write FSM next state, next ready/valid values and the write strobe.
    always_comb begin
        w_state_s = w_state_r;
        awready_s = awready_r;
        wready_s  = wready_r;
        bvalid_s  = bvalid_r;
        wr_en     = 1'b0;
        case (w_state_r)
            W_IDLE: begin
                if (aw_fire_s && w_fire_s) begin
                    wr_en = 1'b1; w_state_s = W_RESP;
                    awready_s = 1'b0; wready_s = 1'b0; bvalid_s = 1'b1;
                end else if (aw_fire_s) begin
                    w_state_s = W_HAVE_AW; awready_s = 1'b0; wready_s = 1'b1;
                end else if (w_fire_s) begin
                    w_state_s = W_HAVE_W; awready_s = 1'b1; wready_s = 1'b0;
                end else begin
                    awready_s = 1'b1; wready_s = 1'b1;
                end
            end
            W_HAVE_AW: begin
                if (w_fire_s) begin
                    wr_en = 1'b1; w_state_s = W_RESP; wready_s = 1'b0; bvalid_s = 1'b1;
                end else begin
                    w_state_s = W_HAVE_AW;
                end
            end
            W_HAVE_W: begin
                if (aw_fire_s) begin
                    wr_en = 1'b1; w_state_s = W_RESP; awready_s = 1'b0; bvalid_s = 1'b1;
                end else begin
                    w_state_s = W_HAVE_W;
                end
            end
            W_RESP: begin
                if (bready) begin
                    w_state_s = W_IDLE; awready_s = 1'b1; wready_s = 1'b1; bvalid_s = 1'b0;
                end else begin
                    w_state_s = W_RESP;
                end
            end
            default: begin
                w_state_s = W_IDLE; awready_s = 1'b0; wready_s = 1'b0; bvalid_s = 1'b0;
            end
        endcase
    end

    // Read FSM next state and next ready/valid values.
    always_comb begin
        r_state_s = r_state_r;
        arready_s = arready_r;
        rvalid_s  = rvalid_r;
        case (r_state_r)
            R_IDLE: begin
                if (ar_fire_s) begin
                    r_state_s = R_RESP; arready_s = 1'b0; rvalid_s = 1'b1;
                end else begin
                    arready_s = 1'b1;
                end
            end
            R_RESP: begin
                if (rready) begin
                    r_state_s = R_IDLE; arready_s = 1'b1; rvalid_s = 1'b0;
                end else begin
                    r_state_s = R_RESP;
                end
            end
            default: begin
                r_state_s = R_IDLE; arready_s = 1'b0; rvalid_s = 1'b0;
            end
        endcase
    end

    // Write channel state, latched AW/W halves and registered response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_state_r <= W_IDLE;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            bresp_r   <= OKAY;
            aw_addr_r <= '0;
            w_data_r  <= '0;
            w_strb_r  <= '0;
        end else begin
            w_state_r <= w_state_s;
            awready_r <= awready_s;
            wready_r  <= wready_s;
            bvalid_r  <= bvalid_s;
            if (aw_fire_s) aw_addr_r <= awaddr;
            if (w_fire_s) begin
                w_data_r <= wdata;
                w_strb_r <= wstrb;
            end
            if (wr_en) bresp_r <= wr_err ? SLVERR : OKAY;
        end
    end

    // Read channel state and registered read data/response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_r <= R_IDLE;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= '0;
            rresp_r   <= OKAY;
        end else begin
            r_state_r <= r_state_s;
            arready_r <= arready_s;
            rvalid_r  <= rvalid_s;
            if (ar_fire_s) begin
                rdata_r <= rd_data;
                rresp_r <= rd_err ? SLVERR : OKAY;
            end
        end
    end

endmodule

// File: rtl/nf10_cutter_axi_lite_regs.sv
// Packet-cutter configuration register file behind an AXI4-Lite slave; staged values
// commit on packet boundaries. Define NF10_CUTTER_STATS_EN to build the PKT_CNT counter.
module nf10_cutter_axi_lite_regs
    import nf10_cutter_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR         = 32'h77800000,
    parameter logic [31:0] C_HIGHADDR         = 32'h7780FFFF,
    parameter int          C_S_AXI_ADDR_WIDTH = 32,
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter logic [31:0] C_VERSION          = 32'h00010000
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic                            pkt_boundary,
    input  logic                            pkt_cut,
    output logic                            cut_en,
    output logic [31:0]                     cut_word,
    output logic [31:0]                     cut_offset,
    output logic [15:0]                     cut_bytes
);

    logic                          wr_en_s, rd_en_s, wr_hit_s, rd_hit_s;
    logic [C_S_AXI_ADDR_WIDTH-1:0] wr_addr_s, rd_addr_s;
    logic [31:0]                   wr_data_s, rd_data_s, rd_mux_s, wr_old_s, wr_new_s, pkt_cnt_s;
    logic [3:0]                    wr_strb_s;
    logic [5:0]                    wr_idx_s, rd_idx_s;
    logic                          en_r, cut_en_r;
    logic [31:0]                   word_r, offset_r, cut_word_r, cut_offset_r;
    logic [15:0]                   bytes_r, cut_bytes_r;

    nf10_cutter_axi_lite_ctrl #(
        .ADDR_W (C_S_AXI_ADDR_WIDTH),
        .DATA_W (C_S_AXI_DATA_WIDTH)
    ) u_ctrl (
        .clk     (S_AXI_ACLK),
        .rst_n   (S_AXI_ARESETN),
        .awaddr  (S_AXI_AWADDR),
        .awvalid (S_AXI_AWVALID),
        .awready (S_AXI_AWREADY),
        .wdata   (S_AXI_WDATA),
        .wstrb   (S_AXI_WSTRB),
        .wvalid  (S_AXI_WVALID),
        .wready  (S_AXI_WREADY),
        .bresp   (S_AXI_BRESP),
        .bvalid  (S_AXI_BVALID),
        .bready  (S_AXI_BREADY),
        .araddr  (S_AXI_ARADDR),
        .arvalid (S_AXI_ARVALID),
        .arready (S_AXI_ARREADY),
        .rdata   (S_AXI_RDATA),
        .rresp   (S_AXI_RRESP),
        .rvalid  (S_AXI_RVALID),
        .rready  (S_AXI_RREADY),
        .wr_en   (wr_en_s),
        .wr_addr (wr_addr_s),
        .wr_data (wr_data_s),
        .wr_strb (wr_strb_s),
        .wr_err  (~wr_hit_s),
        .rd_en   (rd_en_s),
        .rd_addr (rd_addr_s),
        .rd_data (rd_data_s),
        .rd_err  (~rd_hit_s)
    );

    assign wr_hit_s = (wr_addr_s >= C_BASEADDR) && (wr_addr_s <= C_HIGHADDR);
    assign rd_hit_s = (rd_addr_s >= C_BASEADDR) && (rd_addr_s <= C_HIGHADDR);
    assign wr_idx_s = wr_addr_s[7:2] - C_BASEADDR[7:2];
    assign rd_idx_s = rd_addr_s[7:2] - C_BASEADDR[7:2];

    // Merge the write data into the addressed staged register under the byte strobes.
    always_comb begin
        wr_old_s = 32'h0;
        case (wr_idx_s)
            CUT_EN_OFF[7:2]: wr_old_s = {31'h0, en_r};
            WORD_OFF[7:2]:   wr_old_s = word_r;
            OFFSET_OFF[7:2]: wr_old_s = offset_r;
            BYTES_OFF[7:2]:  wr_old_s = {16'h0, bytes_r};
            default:         wr_old_s = 32'h0;
        endcase
        wr_new_s = apply_strb(wr_old_s, wr_data_s, wr_strb_s);
    end

    // Staged configuration registers, updated by in-window AXI writes.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            en_r     <= 1'b0;
            word_r   <= 32'h0;
            offset_r <= 32'h0;
            bytes_r  <= 16'h0;
        end else if (wr_en_s && wr_hit_s) begin
            case (wr_idx_s)
                CUT_EN_OFF[7:2]: en_r     <= wr_new_s[0];
                WORD_OFF[7:2]:   word_r   <= wr_new_s;
                OFFSET_OFF[7:2]: offset_r <= wr_new_s;
                BYTES_OFF[7:2]:  bytes_r  <= wr_new_s[15:0];
                default:         en_r     <= en_r;
            endcase
        end
    end

`ifdef NF10_CUTTER_STATS_EN
    logic [31:0] pkt_cnt_r;
    logic        cnt_clr_s;

    assign cnt_clr_s = wr_en_s && wr_hit_s && (wr_idx_s == PKT_CNT_OFF[7:2]);
    assign pkt_cnt_s = pkt_cnt_r;

    // Saturating frame-cut counter; a register write clears it and beats a same-cycle cut.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            pkt_cnt_r <= 32'h0;
        end else if (cnt_clr_s) begin
            pkt_cnt_r <= 32'h0;
        end else if (pkt_cut && (pkt_cnt_r != 32'hFFFFFFFF)) begin
            pkt_cnt_r <= pkt_cnt_r + 32'd1;
        end
    end
`else
    logic unused_pkt_cut_s;

    assign unused_pkt_cut_s = pkt_cut;
    assign pkt_cnt_s        = 32'h0;
`endif

    // Read mux over staged values; out-of-window or unmapped offsets return zero.
    always_comb begin
        rd_mux_s = 32'h0;
        if (rd_hit_s) begin
            case (rd_idx_s)
                CUT_EN_OFF[7:2]:  rd_mux_s = {31'h0, en_r};
                WORD_OFF[7:2]:    rd_mux_s = word_r;
                OFFSET_OFF[7:2]:  rd_mux_s = offset_r;
                BYTES_OFF[7:2]:   rd_mux_s = {16'h0, bytes_r};
                PKT_CNT_OFF[7:2]: rd_mux_s = pkt_cnt_s;
                VERSION_OFF[7:2]: rd_mux_s = C_VERSION;
                default:          rd_mux_s = 32'h0;
            endcase
        end else begin
            rd_mux_s = 32'h0;
        end
    end

    assign rd_data_s = rd_en_s ? rd_mux_s : 32'h0;

    // Commit staged settings only between frames, or freely while cutting is off.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            cut_en_r     <= 1'b0;
            cut_word_r   <= 32'h0;
            cut_offset_r <= 32'h0;
            cut_bytes_r  <= 16'h0;
        end else if (pkt_boundary || !cut_en_r) begin
            cut_en_r     <= en_r;
            cut_word_r   <= word_r;
            cut_offset_r <= offset_r;
            cut_bytes_r  <= bytes_r;
        end
    end

    assign cut_en     = cut_en_r;
    assign cut_word   = cut_word_r;
    assign cut_offset = cut_offset_r;
    assign cut_bytes  = cut_bytes_r;

endmodule

// File: tb/tb_nf10_cutter_axi_lite_regs.sv
// Self-checking bench for nf10_cutter_axi_lite_regs: expected B/R responses are queued
// when a transaction is driven and compared when the DUT returns them.
module tb_nf10_cutter_axi_lite_regs;

    localparam logic [31:0] BASE = 32'h77800000;

    logic        S_AXI_ACLK = 1'b0;
    logic        S_AXI_ARESETN;
    logic [31:0] S_AXI_AWADDR, S_AXI_WDATA, S_AXI_ARADDR, S_AXI_RDATA;
    logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
    logic [3:0]  S_AXI_WSTRB;
    logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
    logic        S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
    logic        S_AXI_RVALID, S_AXI_RREADY;
    logic        pkt_boundary, pkt_cut, cut_en;
    logic [31:0] cut_word, cut_offset;
    logic [15:0] cut_bytes;

    int n_checks = 0;
    int n_pass   = 0;
    int lat;
    logic [1:0]  exp_b_q[$];
    logic [33:0] exp_r_q[$];

    always #5 S_AXI_ACLK = ~S_AXI_ACLK;

    nf10_cutter_axi_lite_regs dut (
        .S_AXI_ACLK(S_AXI_ACLK), .S_AXI_ARESETN(S_AXI_ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
        .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .pkt_boundary(pkt_boundary), .pkt_cut(pkt_cut), .cut_en(cut_en),
        .cut_word(cut_word), .cut_offset(cut_offset), .cut_bytes(cut_bytes)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Write with optional AW delay (W first) and optional BREADY hold after BVALID.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic [1:0] exp_resp, input int aw_delay, input int hold,
                             output int b_lat);
        int   n;
        logic aw_sent, aw_f, w_f;
        exp_b_q.push_back(exp_resp);
        @(negedge S_AXI_ACLK);
        S_AXI_BREADY  = (hold == 0);
        S_AXI_AWADDR  = addr;
        S_AXI_WDATA   = data;
        S_AXI_WSTRB   = strb;
        S_AXI_WVALID  = 1'b1;
        aw_sent       = (aw_delay == 0);
        S_AXI_AWVALID = aw_sent;
        n = 0;
        while ((!aw_sent || S_AXI_AWVALID || S_AXI_WVALID) && n < 100) begin
            aw_f = S_AXI_AWVALID && S_AXI_AWREADY;
            w_f  = S_AXI_WVALID && S_AXI_WREADY;
            @(negedge S_AXI_ACLK);
            n++;
            if (aw_f) S_AXI_AWVALID = 1'b0;
            if (w_f)  S_AXI_WVALID  = 1'b0;
            if (!aw_sent) begin
                check_val("no_bvalid_before_aw", {31'h0, S_AXI_BVALID}, 32'h0);
                if (n >= aw_delay) begin
                    S_AXI_AWVALID = 1'b1;
                    aw_sent       = 1'b1;
                end
            end
        end
        if (n >= 100) check_val("aw_w_handshake_timeout", n, 32'd0);
        n = 0;
        while (!S_AXI_BVALID && n < 20) begin
            @(negedge S_AXI_ACLK);
            n++;
        end
        b_lat = n;
        check_val("bvalid", {31'h0, S_AXI_BVALID}, 32'h1);
        check_val("bresp", {30'h0, S_AXI_BRESP}, {30'h0, exp_b_q.pop_front()});
        for (int k = 0; k < hold; k++) begin
            @(negedge S_AXI_ACLK);
            check_val("bvalid_hold", {31'h0, S_AXI_BVALID}, 32'h1);
            check_val("awready_hold", {31'h0, S_AXI_AWREADY}, 32'h0);
            check_val("wready_hold", {31'h0, S_AXI_WREADY}, 32'h0);
        end
        S_AXI_BREADY = 1'b1;
        @(negedge S_AXI_ACLK);
        check_val("bvalid_clr", {31'h0, S_AXI_BVALID}, 32'h0);
        check_val("awready_back", {31'h0, S_AXI_AWREADY}, 32'h1);
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp);
        int          n;
        logic [33:0] e;
        exp_r_q.push_back({exp_resp, exp_data});
        @(negedge S_AXI_ACLK);
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        n = 0;
        while (!S_AXI_ARREADY && n < 20) begin
            @(negedge S_AXI_ACLK);
            n++;
        end
        @(negedge S_AXI_ACLK);
        S_AXI_ARVALID = 1'b0;
        n = 0;
        while (!S_AXI_RVALID && n < 20) begin
            @(negedge S_AXI_ACLK);
            n++;
        end
        check_val("rvalid", {31'h0, S_AXI_RVALID}, 32'h1);
        e = exp_r_q.pop_front();
        check_val("rdata", S_AXI_RDATA, e[31:0]);
        check_val("rresp", {30'h0, S_AXI_RRESP}, {30'h0, e[33:32]});
        @(negedge S_AXI_ACLK);
        check_val("rvalid_clr", {31'h0, S_AXI_RVALID}, 32'h0);
    endtask

    task automatic pulse_cut(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            @(negedge S_AXI_ACLK);
            pkt_cut = 1'b1;
            @(negedge S_AXI_ACLK);
            pkt_cut = 1'b0;
        end
    endtask

    initial begin
        S_AXI_ARESETN = 1'b0;
        S_AXI_AWADDR = 32'h0; S_AXI_AWVALID = 1'b0; S_AXI_WDATA = 32'h0; S_AXI_WSTRB = 4'h0;
        S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b1; S_AXI_ARADDR = 32'h0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b1; pkt_boundary = 1'b0; pkt_cut = 1'b0;
        repeat (3) @(negedge S_AXI_ACLK);
        check_val("rst_awready", {31'h0, S_AXI_AWREADY}, 32'h0);
        check_val("rst_arready", {31'h0, S_AXI_ARREADY}, 32'h0);
        check_val("rst_bvalid", {31'h0, S_AXI_BVALID}, 32'h0);
        check_val("rst_rvalid", {31'h0, S_AXI_RVALID}, 32'h0);
        check_val("rst_cut_word", cut_word, 32'h0);
        check_val("rst_cut_en", {31'h0, cut_en}, 32'h0);
        S_AXI_ARESETN = 1'b1;
        @(negedge S_AXI_ACLK);
        check_val("post_rst_awready", {31'h0, S_AXI_AWREADY}, 32'h1);
        check_val("post_rst_wready", {31'h0, S_AXI_WREADY}, 32'h1);
        check_val("post_rst_arready", {31'h0, S_AXI_ARREADY}, 32'h1);

        // Same-cycle AW+W to WORD
        axi_write(BASE + 32'h04, 32'h1, 4'hF, 2'b00, 0, 0, lat);
        check_val("b_latency", lat, 32'd0);
        axi_read(BASE + 32'h04, 32'h1, 2'b00);
        pkt_boundary = 1'b1;
        @(negedge S_AXI_ACLK);
        check_val("cut_word", cut_word, 32'h1);

        // W leads AW by 3 cycles
        axi_write(BASE + 32'h0C, 32'h4B, 4'hF, 2'b00, 3, 0, lat);
        axi_read(BASE + 32'h0C, 32'h0000004B, 2'b00);
        check_val("cut_bytes", {16'h0, cut_bytes}, 32'h4B);

        // Commit gated by packet boundary once enabled
        pkt_boundary = 1'b0;
        axi_write(BASE + 32'h00, 32'h1, 4'hF, 2'b00, 0, 0, lat);
        check_val("cut_en", {31'h0, cut_en}, 32'h1);
        axi_write(BASE + 32'h08, 32'hFFE00000, 4'hF, 2'b00, 0, 0, lat);
        axi_read(BASE + 32'h08, 32'hFFE00000, 2'b00);
        check_val("cut_offset_held", cut_offset, 32'h0);
        pkt_boundary = 1'b1;
        @(negedge S_AXI_ACLK);
        check_val("cut_offset_commit", cut_offset, 32'hFFE00000);

        // Out-of-window accesses
        axi_write(32'h77810000, 32'hFFFFFFFF, 4'hF, 2'b10, 0, 0, lat);
        axi_read(32'h77900000, 32'h0, 2'b10);
        axi_read(BASE + 32'h04, 32'h1, 2'b00);
        axi_read(BASE + 32'h00, 32'h1, 2'b00);
        axi_read(BASE + 32'h08, 32'hFFE00000, 2'b00);

        // Byte strobes, version, unmapped offset
        axi_write(BASE + 32'h04, 32'hAABBCCDD, 4'b0010, 2'b00, 0, 0, lat);
        axi_read(BASE + 32'h04, 32'h0000CC01, 2'b00);
        axi_write(BASE + 32'h04, 32'h12345678, 4'b0000, 2'b00, 0, 0, lat);
        axi_read(BASE + 32'h04, 32'h0000CC01, 2'b00);
        axi_write(BASE + 32'h14, 32'h5A5A5A5A, 4'hF, 2'b00, 0, 0, lat);
        axi_read(BASE + 32'h14, 32'h00010000, 2'b00);
        axi_write(BASE + 32'h18, 32'h5A5A5A5A, 4'hF, 2'b00, 0, 0, lat);
        axi_read(BASE + 32'h18, 32'h0, 2'b00);

`ifdef NF10_CUTTER_STATS_EN
        pulse_cut(5);
        axi_read(BASE + 32'h10, 32'd5, 2'b00);
        fork
            axi_write(BASE + 32'h10, 32'h0, 4'hF, 2'b00, 0, 0, lat);
            begin
                @(negedge S_AXI_ACLK);
                pkt_cut = 1'b1;
                @(negedge S_AXI_ACLK);
                pkt_cut = 1'b0;
            end
        join
        axi_read(BASE + 32'h10, 32'd0, 2'b00);
        force dut.pkt_cnt_r = 32'hFFFFFFFF;
        @(negedge S_AXI_ACLK);
        release dut.pkt_cnt_r;
        pulse_cut(1);
        axi_read(BASE + 32'h10, 32'hFFFFFFFF, 2'b00);
`else
        pulse_cut(5);
        axi_read(BASE + 32'h10, 32'h0, 2'b00);
        axi_write(BASE + 32'h10, 32'h0, 4'hF, 2'b00, 0, 0, lat);
`endif

        // BREADY held low for 4 cycles
        axi_write(BASE + 32'h0C, 32'h1234, 4'hF, 2'b00, 0, 4, lat);
        axi_read(BASE + 32'h0C, 32'h1234, 2'b00);

        // Concurrent read and write of the same register returns the old value
        fork
            axi_write(BASE + 32'h04, 32'hCAFEF00D, 4'hF, 2'b00, 0, 0, lat);
            axi_read(BASE + 32'h04, 32'h0000CC01, 2'b00);
        join
        axi_read(BASE + 32'h04, 32'hCAFEF00D, 2'b00);

        // Reset in the middle of a write drops it without a response
        @(negedge S_AXI_ACLK);
        S_AXI_AWADDR  = BASE + 32'h04;
        S_AXI_AWVALID = 1'b1;
        @(negedge S_AXI_ACLK);
        S_AXI_AWVALID = 1'b0;
        S_AXI_ARESETN = 1'b0;
        @(negedge S_AXI_ACLK);
        S_AXI_ARESETN = 1'b1;
        repeat (3) begin
            @(negedge S_AXI_ACLK);
            check_val("no_b_after_reset", {31'h0, S_AXI_BVALID}, 32'h0);
        end
        check_val("awready_after_reset", {31'h0, S_AXI_AWREADY}, 32'h1);
        check_val("cut_word_after_reset", cut_word, 32'h0);
        axi_read(BASE + 32'h04, 32'h0, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/nf10_cutter_axi_lite_regs.md
Name: nf10_cutter_axi_lite_regs

Overview:
- AXI4-Lite slave register file holding the packet-cutter configuration: enable, word select, offset mask and byte count.
- Responder end of the control path that the monitor host and benches drive as master.
- Drives configuration to the cutter datapath. Staged values are committed only on a packet boundary, so a frame is never cut under mixed settings.
- Sits between the AXI-Lite interconnect and the cutter datapath.

Parameters:
C_BASEADDR, 32'h77800000, base of register window
C_HIGHADDR, 32'h7780FFFF, top of register window
C_S_AXI_ADDR_WIDTH, 32, AXI address width
C_S_AXI_DATA_WIDTH, 32, AXI data width (only 32 supported)
C_VERSION, 32'h00010000, value returned at offset 0x14

Ports:
S_AXI_ACLK  in  1  single clock
S_AXI_ARESETN  in  1  reset; synchronous, active-low
S_AXI_AWADDR  in  32  write address
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  32  read address
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
pkt_boundary  in  1  datapath idle between frames (tlast accepted or idle)
pkt_cut  in  1  one-cycle pulse per frame truncated
cut_en  out  1  committed enable
cut_word  out  32  committed word select
cut_offset  out  32  committed offset/byte mask
cut_bytes  out  16  committed byte count

Behaviour:
- Reset: all AXI outputs 0; all staged and committed registers 0; counter 0. AWREADY, WREADY and ARREADY rise on the first cycle after reset deasserts.
- Register map (offset = addr - C_BASEADDR, bits [7:2] decode):
  - 0x00 CUT_EN, bit0 RW
  - 0x04 WORD RW
  - 0x08 OFFSET RW
  - 0x0C BYTES [15:0] RW
  - 0x10 PKT_CNT RO; any write clears it
  - 0x14 VERSION RO
  - Other offsets inside the window read 0 and ignore writes, with OKAY.
  - Address outside [C_BASEADDR, C_HIGHADDR]: SLVERR (2'b10), no side effect.
- Write FSM states W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
  - AW and W are accepted independently, in either order or in the same cycle; each is latched and its READY drops.
  - When both are held, the write executes and BVALID=1 the next cycle.
  - BVALID holds until BREADY; then both READYs return to 1 and the FSM returns to W_IDLE.
  - A single-cycle AWVALID+WVALID pulse with READYs high completes a write.
- WSTRB: per-byte masked update of the staged register. WSTRB=0 leaves the register unchanged but still returns OKAY.
- Read FSM states R_IDLE, R_RESP.
  - On ARVALID&ARREADY, RDATA/RRESP are registered and RVALID=1 one cycle later.
  - ARREADY=0 while RVALID is pending; RVALID clears on RREADY.
  - Reads return staged values, not committed ones.
- Read and write channels are independent; simultaneous read and write are legal. A same-cycle read of a register being written returns the pre-write value.
- Commit: committed outputs load from staged registers in any cycle where pkt_boundary=1 or committed cut_en=0. Latency is 1 cycle after the staged write or after boundary assertion, whichever is later.
- PKT_CNT: +1 per pkt_cut, saturating at 32'hFFFFFFFF. Write-clear and pkt_cut in the same cycle: clear wins, result 0.
- Reset asserted mid-transaction: pending AW/W/AR are dropped; no response is issued.

Optional Feature:
- NF10_CUTTER_STATS_EN defined: PKT_CNT implemented as above.
- Undefined: no counter logic; 0x10 reads 0, writes to it are OKAY with no effect, and pkt_cut is unused.

Decomposition:
- Package nf10_cutter_pkg: register offset localparams (CUT_EN_OFF=0x00 … VERSION_OFF=0x14), BRESP/RRESP codes (OKAY=2'b00, SLVERR=2'b10), write/read FSM state encodings.
- One natural sub-module, nf10_cutter_axi_lite_ctrl: the AW/W/B and AR/R handshake FSMs. It exposes wr_en/wr_addr/wr_data/wr_strb and rd_en/rd_addr/rd_data, so the register file stays purely a decode/store block.

Test Plan:
- Same-cycle AW+W pulse to 0x77800004, data 1, strobe F -> BVALID one cycle later, BRESP=00; read back 1; cut_word=1 once pkt_boundary=1.
- W presented 3 cycles before AW to 0x7780000C, data 0x4B -> write completes only after AW; BYTES reads 0x004B; no BVALID before AW.
- cut_en=1, pkt_boundary=0; write OFFSET=0xFFE00000 -> readback 0xFFE00000, cut_offset unchanged; assert pkt_boundary -> cut_offset=0xFFE00000 next cycle.
- Write 0x77810000 and read 0x77900000 -> SLVERR on both; all registers unchanged.
- STATS_EN: 5 pkt_cut pulses -> PKT_CNT=5; write 0x10 in the same cycle as a pkt_cut -> PKT_CNT=0; preset 0xFFFFFFFF, pulse -> stays 0xFFFFFFFF.
- Hold BREADY=0 for 4 cycles after a write -> BVALID held; AWREADY/WREADY stay 0; a second write is not accepted until B completes.
